// File: rtl/gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_irq_ctrl
//
// Interrupt controller for the GPIO pads (pmod A = [23:16], B = [15:8],
// C = [7:0] in the default 24-pin build). Each pad is synchronised and
// edge-detected with a per-pin polarity. Detected edges latch into PENDING.
// A fixed-priority arbiter picks the lowest enabled pending pin, and the core
// services it through a CLAIM read / COMPLETE write handshake.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   gpio_in_i  raw pad levels, asynchronous to clk
//   sel_i      register access request
//   we_i       1 = write, 0 = read
//   addr_i     byte address, only [4:2] decoded
//   wdata_i    write data
//   rdata_o    read data, valid while ack_o = 1, zero otherwise
//   ack_o      one-cycle acknowledge, one cycle after the access cycle
//   irq_o      registered interrupt request to the core
//
// Register map (addr_i[4:2])
//   0 IE        RW  per-pin enable, masks arbitration and irq_o only
//   1 POL       RW  1 = rising edge, 0 = falling edge
//   2 PENDING   R   latched events; write 1 to clear
//   3 CLAIM     R   winner id (pin + 1) and enter service; 0 = none
//   4 COMPLETE  W   wdata[4:0] = id being completed
//   5 STATUS    R   bit0 = in service, bits [12:8] = claimed id
//   6,7         read 0, write ignored, still acknowledged
// ---------------------------------------------------------------------------
module gpio_irq_ctrl #(
    parameter int NUM_PINS    = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PINS-1:0] gpio_in_i,
    input  logic                sel_i,
    input  logic                we_i,
    input  logic [7:0]          addr_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o,
    output logic                ack_o,
    output logic                irq_o
);

    // Register offsets as seen on addr_i[4:2]
    localparam logic [2:0] ADDR_IE       = 3'd0;
    localparam logic [2:0] ADDR_POL      = 3'd1;
    localparam logic [2:0] ADDR_PENDING  = 3'd2;
    localparam logic [2:0] ADDR_CLAIM    = 3'd3;
    localparam logic [2:0] ADDR_COMPLETE = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;

    // Edge detection stays off until the synchroniser and prev flop hold real
    // pad levels, so a pin that is already high at reset is not an event.
    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

    typedef enum logic {
        IDLE       = 1'b0,
        IN_SERVICE = 1'b1
    } svcState_e;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    logic [NUM_PINS-1:0] syncReg [SYNC_STAGES];
    logic [NUM_PINS-1:0] prevLevel;
    logic [NUM_PINS-1:0] syncLevel;
    logic [WARM_W-1:0]   warmCnt;
    logic                warmDone;
    logic [NUM_PINS-1:0] edgeHit;

    logic [NUM_PINS-1:0] ie;
    logic [NUM_PINS-1:0] pol;
    logic [NUM_PINS-1:0] pending;
    logic [NUM_PINS-1:0] pendingNext;
    logic [NUM_PINS-1:0] activeMask;
    logic [NUM_PINS-1:0] w1cMask;
    logic [NUM_PINS-1:0] claimMask;
    logic [4:0]          winnerId;
    logic [4:0]          claimedId;

    svcState_e           state;
    svcState_e           stateNext;
    logic                claimTake;
    logic                completeOk;

    logic                access;
    logic                rdAccess;
    logic                wrAccess;
    logic [2:0]          regSel;
    logic [31:0]         readData;

    // Address/data bits that the register map never looks at.
    logic                unusedBits;
    assign unusedBits = ^{addr_i[7:5], addr_i[1:0], wdata_i[31:NUM_PINS]};

    // -----------------------------------------------------------------------
    // Pad synchroniser and previous-level flop
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbour; = here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is a flop chain, not a RAM, so every stage is
            // reset; a real memory array would be left unreset.
            for (int s = 0; s < SYNC_STAGES; s++) begin
                syncReg[s] <= '0;
            end
            prevLevel <= '0;
        end else begin
            syncReg[0] <= gpio_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                syncReg[s] <= syncReg[s-1];
            end
            prevLevel <= syncReg[SYNC_STAGES-1];
        end
    end

    assign syncLevel = syncReg[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Warm-up counter: saturates at WARM_CYCLES after reset release
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warmCnt <= '0;
        end else if (!warmDone) begin
            warmCnt <= warmCnt + WARM_W'(1);
        end
    end

    assign warmDone = (warmCnt == WARM_W'(WARM_CYCLES));

    // Per-pin edge select: rising where POL=1, falling where POL=0
    assign edgeHit = warmDone
                   ? ((pol & syncLevel & ~prevLevel) | (~pol & ~syncLevel & prevLevel))
                   : '0;

    // -----------------------------------------------------------------------
    // Bus decode: an access is a selected cycle that is not the ack cycle
    // -----------------------------------------------------------------------
    assign access   = sel_i & ~ack_o;
    assign wrAccess = access & we_i;
    assign rdAccess = access & ~we_i;
    assign regSel   = addr_i[4:2];

    // -----------------------------------------------------------------------
    // Fixed-priority arbiter: lowest enabled pending pin wins, id = pin + 1
    // -----------------------------------------------------------------------
    assign activeMask = pending & ie;

    always_comb begin
        // NOTE: default first so every path assigns winnerId and no latch forms.
        winnerId = '0;
        // Scanning downward lets the lowest index overwrite higher ones.
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (activeMask[i]) begin
                winnerId = 5'(i + 1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Service FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        claimTake  = 1'b0;
        completeOk = 1'b0;
        case (state)
            IDLE: begin
                // A CLAIM with nothing to serve is a plain read of 0.
                if (rdAccess && (regSel == ADDR_CLAIM) && (winnerId != 5'd0)) begin
                    claimTake = 1'b1;
                    stateNext = IN_SERVICE;
                end
            end
            IN_SERVICE: begin
                // Only the id that was claimed can close the service window.
                if (wrAccess && (regSel == ADDR_COMPLETE) && (wdata_i[4:0] == claimedId)) begin
                    completeOk = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // PENDING update: clears first, then new edges OR'd in so a same-cycle
    // event always survives a W1C or a claim of the same bit.
    // -----------------------------------------------------------------------
    assign w1cMask   = (wrAccess && (regSel == ADDR_PENDING)) ? wdata_i[NUM_PINS-1:0] : '0;
    assign claimMask = claimTake ? (NUM_PINS'(1) << (winnerId - 5'd1)) : '0;

    assign pendingNext = (pending & ~w1cMask & ~claimMask) | edgeHit;

    // -----------------------------------------------------------------------
    // Configuration, pending, claimed id and the registered irq
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie        <= '0;
            pol       <= '0;
            pending   <= '0;
            claimedId <= '0;
            irq_o     <= 1'b0;
        end else begin
            if (wrAccess && (regSel == ADDR_IE)) begin
                ie <= wdata_i[NUM_PINS-1:0];
            end
            if (wrAccess && (regSel == ADDR_POL)) begin
                pol <= wdata_i[NUM_PINS-1:0];
            end
            pending <= pendingNext;
            if (claimTake) begin
                claimedId <= winnerId;
            end else if (completeOk) begin
                claimedId <= '0;
            end
            // Built from current register values, so irq_o follows PENDING,
            // IE and state one cycle later.
            irq_o <= (state == IDLE) && (|activeMask);
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and bus response
    // -----------------------------------------------------------------------
    always_comb begin
        readData = '0;
        case (regSel)
            ADDR_IE:      readData[NUM_PINS-1:0] = ie;
            ADDR_POL:     readData[NUM_PINS-1:0] = pol;
            ADDR_PENDING: readData[NUM_PINS-1:0] = pending;
            ADDR_CLAIM:   readData[4:0]          = (state == IDLE) ? winnerId : 5'd0;
            ADDR_STATUS: begin
                readData[0]    = (state == IN_SERVICE);
                readData[12:8] = claimedId;
            end
            default:      readData = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            ack_o   <= access;
            rdata_o <= rdAccess ? readData : '0;
        end
    end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_irq_ctrl
//
// Directed bench for gpio_irq_ctrl (24 pins, 2 synchroniser stages).
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, away from the active edge.
// ---------------------------------------------------------------------------
module tb_gpio_irq_ctrl;

    localparam logic [7:0] A_IE       = 8'h00;
    localparam logic [7:0] A_POL      = 8'h04;
    localparam logic [7:0] A_PENDING  = 8'h08;
    localparam logic [7:0] A_CLAIM    = 8'h0C;
    localparam logic [7:0] A_COMPLETE = 8'h10;
    localparam logic [7:0] A_STATUS   = 8'h14;
    localparam logic [7:0] A_UNUSED   = 8'h1C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] gpioIn;
    logic        sel;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;

    int nAssert = 0;
    int nFail   = 0;

    gpio_irq_ctrl #(
        .NUM_PINS    (24),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpio_in_i (gpioIn),
        .sel_i     (sel),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .ack_o     (ack),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input string tag, input logic [7:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        check({tag, "_ack"}, 32'(ack), 32'd1);
        sel = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic readExpect(input string tag, input logic [7:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        #1;
        check({tag, "_ack"}, 32'(ack), 32'd1);
        check(tag, rdata, exp);
        sel = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        gpioIn = 24'hFFFFFF;
        sel    = 1'b0;
        we     = 1'b0;
        addr   = 8'h00;
        wdata  = 32'h0;

        // ---- Reset with all pins high; warm-up must hide the startup rise
        waitCycles(3);
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_irq",   32'(irq), 32'd0);
        check("rst_rdata", rdata,    32'd0);
        rst_n = 1'b1;
        busWrite("pol_all", A_POL, 32'h00FFFFFF);
        busWrite("ie_all",  A_IE,  32'h00FFFFFF);
        waitCycles(10);
        readExpect("warm_pending", A_PENDING, 32'h0);
        check("warm_irq", 32'(irq), 32'd0);

        // ---- Single pin 4 rising edge, claim and status
        gpioIn = 24'h0;
        waitCycles(5);
        busWrite("ie_p4",  A_IE,  32'h10);
        busWrite("pol_p4", A_POL, 32'h10);
        gpioIn[4] = 1'b1;
        waitCycles(4);
        check("p4_irq", 32'(irq), 32'd1);
        gpioIn[4] = 1'b0;
        readExpect("p4_pending", A_PENDING, 32'h10);
        readExpect("p4_claim",   A_CLAIM,   32'd5);
        check("p4_irq_svc", 32'(irq), 32'd0);
        readExpect("p4_status",  A_STATUS,  32'h0501);
        readExpect("p4_pend_clr", A_PENDING, 32'h0);

        // ---- Pin 4 re-fires during its own service
        gpioIn[4] = 1'b1;
        waitCycles(4);
        readExpect("refire_pending", A_PENDING, 32'h10);
        check("refire_irq", 32'(irq), 32'd0);
        busWrite("complete_bad", A_COMPLETE, 32'd3);
        readExpect("bad_status", A_STATUS, 32'h0501);
        busWrite("complete_5", A_COMPLETE, 32'd5);
        check("after_c5_irq", 32'(irq), 32'd1);
        readExpect("idle_status", A_STATUS, 32'h0);
        readExpect("reclaim_5",   A_CLAIM,  32'd5);
        busWrite("complete_5b", A_COMPLETE, 32'd5);
        check("after_c5b_irq", 32'(irq), 32'd0);
        gpioIn[4] = 1'b0;
        waitCycles(5);

        // ---- Pins 3 and 9 rise together; lowest index wins
        busWrite("pol_3_9", A_POL, 32'h208);
        busWrite("ie_3_9",  A_IE,  32'h208);
        gpioIn[3] = 1'b1;
        gpioIn[9] = 1'b1;
        waitCycles(4);
        check("p39_irq", 32'(irq), 32'd1);
        readExpect("p39_pending", A_PENDING, 32'h208);
        readExpect("p39_claim4",  A_CLAIM,   32'd4);
        check("p39_irq_svc", 32'(irq), 32'd0);
        busWrite("complete_4", A_COMPLETE, 32'd4);
        check("after_c4_irq", 32'(irq), 32'd1);
        readExpect("p39_claim10", A_CLAIM, 32'd10);
        busWrite("complete_10", A_COMPLETE, 32'd10);
        check("after_c10_irq", 32'(irq), 32'd0);
        readExpect("p39_pend_clr", A_PENDING, 32'h0);

        // ---- PENDING latches with IE off, but no irq and no claim
        gpioIn[3] = 1'b0;
        gpioIn[9] = 1'b0;
        busWrite("ie_off", A_IE, 32'h0);
        gpioIn[3] = 1'b1;
        waitCycles(4);
        readExpect("mask_pending", A_PENDING, 32'h8);
        check("mask_irq", 32'(irq), 32'd0);
        readExpect("mask_claim",  A_CLAIM,  32'd0);
        readExpect("mask_status", A_STATUS, 32'h0);
        busWrite("w1c_p3", A_PENDING, 32'h8);
        readExpect("w1c_pending", A_PENDING, 32'h0);
        gpioIn[3] = 1'b0;
        waitCycles(5);

        // ---- Falling edge on pin 0, W1C, then W1C racing a new edge
        busWrite("pol_fall", A_POL, 32'h0);
        busWrite("ie_p0",    A_IE,  32'h1);
        gpioIn[0] = 1'b1;
        waitCycles(5);
        readExpect("p0_rise_ignored", A_PENDING, 32'h0);
        gpioIn[0] = 1'b0;
        waitCycles(4);
        readExpect("p0_fall_pending", A_PENDING, 32'h1);
        check("p0_irq", 32'(irq), 32'd1);
        busWrite("w1c_p0", A_PENDING, 32'h1);
        readExpect("p0_cleared", A_PENDING, 32'h0);
        gpioIn[0] = 1'b1;
        waitCycles(5);
        gpioIn[0] = 1'b0;
        // Edge reaches PENDING on the third rising edge, same edge as the W1C.
        repeat (2) @(posedge clk);
        #1;
        busWrite("w1c_race", A_PENDING, 32'h1);
        readExpect("set_wins", A_PENDING, 32'h1);

        // ---- sel held high: accesses every other cycle, rdata only with ack
        sel = 1'b1; we = 1'b0; addr = A_IE;
        #0;
        check("hold_ack_0",   32'(ack), 32'd0);
        check("hold_rdata_0", rdata,    32'd0);
        for (int k = 1; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_ack_%0d", k),   32'(ack), (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("hold_rdata_%0d", k), rdata,    (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        sel = 1'b0;
        @(posedge clk);
        #1;
        readExpect("unmapped_read", A_UNUSED, 32'h0);

        // ---- Reset in the middle of a service window
        readExpect("pre_rst_claim",  A_CLAIM,  32'd1);
        readExpect("pre_rst_status", A_STATUS, 32'h0101);
        gpioIn[0] = 1'b1;
        waitCycles(5);
        gpioIn[0] = 1'b0;
        waitCycles(4);
        readExpect("pre_rst_pending", A_PENDING, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(5);
        readExpect("post_rst_status",  A_STATUS,  32'h0);
        readExpect("post_rst_pending", A_PENDING, 32'h0);
        readExpect("post_rst_ie",      A_IE,      32'h0);
        check("post_rst_irq", 32'(irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
